// File: rtl/norm_engine_p.sv
// Two-pass RMSNorm / LayerNorm engine: pass 1 accumulates sum and sum of squares, pass 2 scales by gamma*inv_rms.
// Optional macro NORM_SAT_CNT_EN adds sat_count, the number of clamped outputs since the last accepted command.
module norm_engine_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int ACC_W     = 32,
    parameter int FRAC_W    = 8,
    parameter int OUT_SHIFT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [ADDR_W-1:0] length,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] gamma_base,
    output logic              sram_rd0_en,
    output logic [ADDR_W-1:0] sram_rd0_addr,
    input  logic [DATA_W-1:0] sram_rd0_data,
    output logic              sram_rd1_en,
    output logic [ADDR_W-1:0] sram_rd1_addr,
    input  logic [DATA_W-1:0] sram_rd1_data,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic [7:0]        lut_addr,
    input  logic [15:0]       lut_data,
    output logic              busy,
    output logic              done
`ifdef NORM_SAT_CNT_EN
    ,
    output logic [ADDR_W-1:0] sat_count
`endif
);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_P1          = 4'd1;
    localparam logic [3:0] S_P1_DRAIN    = 4'd2;
    localparam logic [3:0] S_DIV_MSQ     = 4'd3;
    localparam logic [3:0] S_DIV_MEAN    = 4'd4;
    localparam logic [3:0] S_VAR         = 4'd5;
    localparam logic [3:0] S_RSQRT       = 4'd6;
    localparam logic [3:0] S_RSQRT_LATCH = 4'd7;
    localparam logic [3:0] S_P2          = 4'd8;
    localparam logic [3:0] S_P2_DRAIN    = 4'd9;
    localparam logic [3:0] S_DONE        = 4'd10;

    localparam int DIV_IDX_W = $clog2(ACC_W);
    localparam int PW        = 2*DATA_W + 1;
    localparam int YW        = PW + 17;
    localparam logic [ADDR_W-1:0] DIV_LAST = ADDR_W'(ACC_W-1);
    localparam logic signed [YW-1:0] Y_MAX = {{(YW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [YW-1:0] Y_MIN = {{(YW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [3:0]        state;
    logic              mode_r;
    logic [ADDR_W-1:0] len_r, src_r, dst_r, gam_r;
    logic [ADDR_W-1:0] addr0, addr1, wr_addr_r, cnt;
    logic              p1_vld, p2_vld;
    logic [ACC_W-1:0]  sum, sumsq, rem, msq, mean_q;
    logic [ACC_W-2:0]  quo;
    logic [7:0]        lut_idx;
    logic [15:0]       inv_rms;

    // pass-1 accumulate terms
    logic [2*DATA_W-1:0] x_ext, xsq;
    assign x_ext = {{DATA_W{sram_rd0_data[DATA_W-1]}}, sram_rd0_data};
    assign xsq   = x_ext * x_ext;

    // restoring divider: one dividend bit per cycle, MSB first, indexed by the down-counter
    logic [ACC_W-1:0] abs_sum, dividend, rem_nx, quo_nx;
    logic [ACC_W:0]   rem_sh, rem_diff, len_ext;
    logic             div_ge;
    always_comb begin
        abs_sum  = sum[ACC_W-1] ? -sum : sum;
        dividend = (state == S_DIV_MEAN) ? (abs_sum << FRAC_W) : (sumsq << FRAC_W);
        rem_sh   = {rem, dividend[cnt[DIV_IDX_W-1:0]]};
        len_ext  = {{(ACC_W+1-ADDR_W){1'b0}}, len_r};
        rem_diff = rem_sh - len_ext;
        div_ge   = ~rem_diff[ACC_W];
        rem_nx   = div_ge ? rem_diff[ACC_W-1:0] : rem_sh[ACC_W-1:0];
        quo_nx   = {quo, div_ge};
    end

    logic [2*ACC_W-1:0]        mean_ext, sq_u, var_u, var_int;
    logic signed [2*ACC_W+1:0] var_s;
    logic [7:0]                idx_nx;
    always_comb begin
        mean_ext = {{ACC_W{mean_q[ACC_W-1]}}, mean_q};
        sq_u     = mean_ext * mean_ext;
        var_s    = $signed({2'b00, {ACC_W{1'b0}}, msq}) - $signed({2'b00, sq_u >> FRAC_W});
        var_u    = var_s[2*ACC_W+1] ? '0 : var_s[2*ACC_W-1:0];
        var_int  = var_u >> FRAC_W;
        idx_nx   = (|var_int[2*ACC_W-1:8]) ? 8'hFF : var_int[7:0];
    end

    // pass-2 datapath; integer part of mean_q is the slice above the fraction bits
    logic [DATA_W:0]        c_val;
    logic [PW-1:0]          c_ext, g_ext, p_val;
    logic signed [YW-1:0]   p_ext, inv_ext, y_full, y_sh;
    logic                   sat_hi, sat_lo;
    logic [DATA_W-1:0]      y_val;
    always_comb begin
        c_val   = {sram_rd0_data[DATA_W-1], sram_rd0_data} - mean_q[FRAC_W+DATA_W:FRAC_W];
        c_ext   = {{DATA_W{c_val[DATA_W]}}, c_val};
        g_ext   = {{(DATA_W+1){sram_rd1_data[DATA_W-1]}}, sram_rd1_data};
        p_val   = c_ext * g_ext;
        p_ext   = {{(YW-PW){p_val[PW-1]}}, p_val};
        inv_ext = {{(YW-16){1'b0}}, inv_rms};
        y_full  = p_ext * inv_ext;
        y_sh    = y_full >>> OUT_SHIFT;
        sat_hi  = y_sh > Y_MAX;
        sat_lo  = y_sh < Y_MIN;
        y_val   = sat_hi ? Y_MAX[DATA_W-1:0] : sat_lo ? Y_MIN[DATA_W-1:0] : y_sh[DATA_W-1:0];
    end

    assign cmd_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign sram_rd0_en   = (state == S_P1) || (state == S_P2);
    assign sram_rd0_addr = addr0;
    assign sram_rd1_en   = (state == S_P2);
    assign sram_rd1_addr = addr1;
    assign sram_wr_en    = p2_vld;
    assign sram_wr_addr  = wr_addr_r;
    assign sram_wr_data  = p2_vld ? y_val : '0;
    assign lut_addr      = lut_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode_r    <= 1'b0;
            len_r     <= '0;
            src_r     <= '0;
            dst_r     <= '0;
            gam_r     <= '0;
            addr0     <= '0;
            addr1     <= '0;
            wr_addr_r <= '0;
            cnt       <= '0;
            p1_vld    <= 1'b0;
            p2_vld    <= 1'b0;
            sum       <= '0;
            sumsq     <= '0;
            rem       <= '0;
            quo       <= '0;
            msq       <= '0;
            mean_q    <= '0;
            lut_idx   <= '0;
            inv_rms   <= '0;
        end else begin
            p1_vld <= (state == S_P1);
            p2_vld <= (state == S_P2);
            if (p1_vld) begin
                sum   <= sum + {{(ACC_W-DATA_W){sram_rd0_data[DATA_W-1]}}, sram_rd0_data};
                sumsq <= sumsq + {{(ACC_W-2*DATA_W){1'b0}}, xsq};
            end
            if (p2_vld) wr_addr_r <= wr_addr_r + 1'b1;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    mode_r <= cmd_mode;
                    len_r  <= length;
                    src_r  <= src_base;
                    dst_r  <= dst_base;
                    gam_r  <= gamma_base;
                    addr0  <= src_base;
                    cnt    <= length - 1'b1;
                    sum    <= '0;
                    sumsq  <= '0;
                    mean_q <= '0;
                    state  <= (length == '0) ? S_DONE : S_P1;
                end
                S_P1: begin
                    addr0 <= addr0 + 1'b1;
                    if (cnt == '0) state <= S_P1_DRAIN;
                    else           cnt   <= cnt - 1'b1;
                end
                S_P1_DRAIN: begin
                    cnt   <= DIV_LAST;
                    rem   <= '0;
                    state <= S_DIV_MSQ;
                end
                S_DIV_MSQ: begin
                    rem <= rem_nx;
                    quo <= quo_nx[ACC_W-2:0];
                    if (cnt == '0) begin
                        msq <= quo_nx;
                        if (mode_r) begin
                            cnt   <= DIV_LAST;
                            rem   <= '0;
                            state <= S_DIV_MEAN;
                        end else begin
                            state <= S_VAR;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV_MEAN: begin
                    rem <= rem_nx;
                    quo <= quo_nx[ACC_W-2:0];
                    if (cnt == '0) begin
                        mean_q <= sum[ACC_W-1] ? -quo_nx : quo_nx;
                        state  <= S_VAR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_VAR: begin
                    lut_idx <= idx_nx;
                    state   <= S_RSQRT;
                end
                S_RSQRT: state <= S_RSQRT_LATCH;
                S_RSQRT_LATCH: begin
                    inv_rms   <= lut_data;
                    addr0     <= src_r;
                    addr1     <= gam_r;
                    wr_addr_r <= dst_r;
                    cnt       <= len_r - 1'b1;
                    state     <= S_P2;
                end
                S_P2: begin
                    addr0 <= addr0 + 1'b1;
                    addr1 <= addr1 + 1'b1;
                    if (cnt == '0) state <= S_P2_DRAIN;
                    else           cnt   <= cnt - 1'b1;
                end
                S_P2_DRAIN: state <= S_DONE;
                S_DONE:     state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

`ifdef NORM_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (state == S_IDLE && cmd_valid) begin
            sat_count <= '0;
        end else if (p2_vld && (sat_hi || sat_lo) && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_norm_engine_p.sv
// Self-checking bench for norm_engine_p: directed vector table, busy/reset sequences and randomized jobs.
module tb_norm_engine_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_mode = 1'b0;
    logic [15:0] length = '0, src_base = '0, dst_base = '0, gamma_base = '0;
    logic        sram_rd0_en, sram_rd1_en, sram_wr_en;
    logic [15:0] sram_rd0_addr, sram_rd1_addr, sram_wr_addr;
    logic [7:0]  sram_rd0_data = '0, sram_rd1_data = '0, sram_wr_data;
    logic [7:0]  lut_addr;
    logic [15:0] lut_data = '0;
    logic        busy, done;
`ifdef NORM_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    norm_engine_p dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .length(length), .src_base(src_base), .dst_base(dst_base),
        .gamma_base(gamma_base),
        .sram_rd0_en(sram_rd0_en), .sram_rd0_addr(sram_rd0_addr), .sram_rd0_data(sram_rd0_data),
        .sram_rd1_en(sram_rd1_en), .sram_rd1_addr(sram_rd1_addr), .sram_rd1_data(sram_rd1_data),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
        .lut_addr(lut_addr), .lut_data(lut_data), .busy(busy), .done(done)
`ifdef NORM_SAT_CNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem1 [0:65535];
    logic [15:0] lut_tab [0:255];

    always @(posedge clk) begin
        if (sram_rd0_en) sram_rd0_data <= mem0[sram_rd0_addr];
        if (sram_rd1_en) sram_rd1_data <= mem1[sram_rd1_addr];
        if (sram_wr_en)  mem0[sram_wr_addr] <= sram_wr_data;
        lut_data <= lut_tab[lut_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          acc_q[$], done_q[$], wcyc_q[$];
    logic [15:0] waddr_q[$];
    logic [7:0]  wdata_q[$];
    int          rd_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (sram_wr_en) begin
            wcyc_q.push_back(cyc);
            waddr_q.push_back(sram_wr_addr);
            wdata_q.push_back(sram_wr_data);
        end
        if (sram_rd0_en || sram_rd1_en || sram_wr_en) rd_cnt++;
        if (busy) busy_cnt++;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    int exp_y[$];
    int exp_sat;

    // Reference: plain integer arithmetic on the job's inputs as currently held in the memories.
    task automatic predict(input int mode, input int n, input int src, input int gb);
        longint sum = 0, sq = 0, msq, mean = 0, a, v, idx, inv, mi, c, p, y, xv, gv;
        longint mask = 64'hFFFF_FFFF;
        exp_y.delete();
        exp_sat = 0;
        if (n == 0) return;
        for (int i = 0; i < n; i++) begin
            xv = $signed(mem0[16'(src + i)]);
            sum += xv;
            sq  += xv * xv;
        end
        msq = ((sq << 8) & mask) / n;
        if (mode != 0) begin
            a    = (sum < 0) ? -sum : sum;
            a    = ((a << 8) & mask) / n;
            mean = (sum < 0) ? -a : a;
        end
        v = msq - ((mean * mean) >>> 8);
        if (v < 0) v = 0;
        idx = ((v >>> 8) > 255) ? 255 : (v >>> 8);
        inv = lut_tab[int'(idx)];
        mi  = mean >>> 8;
        for (int i = 0; i < n; i++) begin
            xv = $signed(mem0[16'(src + i)]);
            gv = $signed(mem1[16'(gb + i)]);
            c  = xv - mi;
            p  = c * gv;
            y  = (p * inv) >>> 16;
            if (y > 127) begin y = 127; exp_sat++; end
            else if (y < -128) begin y = -128; exp_sat++; end
            exp_y.push_back(int'(y));
        end
    endtask

    task automatic clear_mon();
        acc_q.delete(); done_q.delete(); wcyc_q.delete(); waddr_q.delete(); wdata_q.delete();
    endtask

    task automatic drive_cmd(input int mode, input int n, input int src, input int dst, input int gb);
        cmd_valid  = 1'b1;
        cmd_mode   = mode[0];
        length     = 16'(n);
        src_base   = 16'(src);
        dst_base   = 16'(dst);
        gamma_base = 16'(gb);
    endtask

    task automatic start_cmd(input int mode, input int n, input int src, input int dst, input int gb);
        int k = 0;
        @(posedge clk); #1;
        drive_cmd(mode, n, src, dst, gb);
        do begin @(negedge clk); k++; end while (!cmd_ready && k < 300);
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done_q.size() == 0 && k < limit) begin @(negedge clk); k++; end
        if (done_q.size() == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_job(input int acc, input int mode, input int n, input int dst);
        int dd = 32 * (1 + mode);
        chk("done_cycle", (done_q.size() > 0) ? done_q[0] - acc : -1, (n == 0) ? 1 : 2*n + 6 + dd);
        chk("wr_count", wcyc_q.size(), n);
        for (int i = 0; i < n && i < wcyc_q.size(); i++) begin
            chk("wr_addr", waddr_q[i], (dst + i) & 16'hFFFF);
            chk("wr_data", int'($signed(wdata_q[i])), exp_y[i]);
            chk("wr_cycle", wcyc_q[i] - acc, n + 6 + dd + i);
        end
`ifdef NORM_SAT_CNT_EN
        chk("sat_count", sat_count, exp_sat);
`endif
    endtask

    task automatic run_job(input int mode, input int n, input int src, input int dst, input int gb);
        predict(mode, n, src, gb);
        clear_mon();
        start_cmd(mode, n, src, dst, gb);
        wait_done(2*n + 100);
        repeat (2) @(negedge clk);
        check_job((acc_q.size() > 0) ? acc_q[0] : 0, mode, n, dst);
        chk("done_pulses", done_q.size(), 1);
    endtask

    task automatic load_rand(input int n, input int src, input int gb);
        for (int i = 0; i < n; i++) begin
            mem0[16'(src + i)] = 8'($urandom_range(0, 255));
            mem1[16'(gb + i)]  = 8'($urandom_range(0, 255));
        end
    endtask

    typedef struct packed {
        logic            mode;
        logic [15:0]     n;
        logic [7:0][7:0] x;
        logic [7:0]      g;
        logic [7:0][7:0] y;
        logic [15:0]     done_rel;
        logic [15:0]     sat;
    } vec_t;

    vec_t vt [0:3];

    initial begin
        int b0, b1, bsy0, acc_b, a_done, w_before;

        for (int i = 0; i < 256; i++) lut_tab[i] = 16'(i * 257 + 300);
        lut_tab[8'h10] = 16'h2000;
        lut_tab[8'hFF] = 16'hFFFF;
        for (int i = 0; i < 65536; i++) begin mem0[i] = '0; mem1[i] = '0; end

        vt[0] = '{mode: 1'b0, n: 16'd4, x: {8{8'h04}}, g: 8'd64,  y: {8{8'd32}}, done_rel: 16'd46, sat: 16'd0};
        vt[1] = '{mode: 1'b1, n: 16'd4, x: {8{8'h04}}, g: 8'd127, y: {8{8'd0}},  done_rel: 16'd78, sat: 16'd0};
        vt[2] = '{mode: 1'b0, n: 16'd2, x: {48'h0, 8'h80, 8'h7F}, g: 8'd127,
                  y: {48'h0, 8'h80, 8'h7F}, done_rel: 16'd42, sat: 16'd2};
        vt[3] = '{mode: 1'b0, n: 16'd0, x: '0, g: 8'd0, y: '0, done_rel: 16'd1, sat: 16'd0};

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_enables", {sram_rd0_en, sram_rd1_en, sram_wr_en}, 0);
        chk("rst_addrs", {sram_rd0_addr, sram_rd1_addr, sram_wr_addr}, 0);
        chk("rst_wr_data", sram_wr_data, 0);
        rst_n = 1'b1;

        // directed table
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) begin
                mem0[16'h0100 + i] = vt[t].x[i];
                mem1[16'h0400 + i] = vt[t].g;
            end
            clear_mon();
            b0 = rd_cnt; bsy0 = busy_cnt;
            start_cmd(int'(vt[t].mode), int'(vt[t].n), 16'h0100, 16'h0600, 16'h0400);
            wait_done(300);
            repeat (2) @(negedge clk);
            chk("vec_done_cycle", (done_q.size() > 0 && acc_q.size() > 0) ? done_q[0] - acc_q[0] : -1,
                vt[t].done_rel);
            chk("vec_wr_count", wcyc_q.size(), vt[t].n);
            for (int i = 0; i < int'(vt[t].n) && i < wdata_q.size(); i++)
                chk("vec_wr_data", int'($signed(wdata_q[i])), int'($signed(vt[t].y[i])));
`ifdef NORM_SAT_CNT_EN
            chk("vec_sat_count", sat_count, vt[t].sat);
`endif
            if (vt[t].n == 0) begin
                chk("len0_no_traffic", rd_cnt - b0, 0);
                chk("len0_busy_cycles", busy_cnt - bsy0, 1);
            end
        end

        // cmd_valid held while busy with other parameters
        load_rand(3, 16'h3000, 16'h0100);
        load_rand(5, 16'h3100, 16'h0200);
        predict(0, 3, 16'h3000, 16'h0100);
        clear_mon();
        start_cmd(0, 3, 16'h3000, 16'h9000, 16'h0100);
        #1 drive_cmd(1, 5, 16'h3100, 16'h9100, 16'h0200);
        wait_done(200);
        a_done = (done_q.size() > 0) ? done_q[0] : 0;
        check_job((acc_q.size() > 0) ? acc_q[0] : 0, 0, 3, 16'h9000);
        chk("held_single_accept", acc_q.size(), 1);
        clear_mon();
        predict(1, 5, 16'h3100, 16'h0200);
        begin
            int k = 0;
            while (acc_q.size() == 0 && k < 20) begin @(negedge clk); k++; end
        end
        acc_b = (acc_q.size() > 0) ? acc_q[0] : -1;
        chk("held_next_accept", acc_b - a_done, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_done(200);
        repeat (2) @(negedge clk);
        check_job(acc_b, 1, 5, 16'h9100);

        // reset in the middle of pass 2
        load_rand(8, 16'h4000, 16'h0300);
        clear_mon();
        start_cmd(0, 8, 16'h4000, 16'hA000, 16'h0300);
        begin
            int k = 0;
            while (wcyc_q.size() < 3 && k < 200) begin @(negedge clk); k++; end
        end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {sram_wr_en, sram_rd0_en, sram_rd1_en, busy, done}, 0);
        chk("midrst_wr_bus", {sram_wr_addr, sram_wr_data}, 0);
        w_before = wcyc_q.size();
        repeat (3) @(negedge clk);
        chk("midrst_no_more_writes", wcyc_q.size(), w_before);
        chk("midrst_partial", (wcyc_q.size() > 0 && wcyc_q.size() < 8) ? 1 : 0, 1);
        chk("midrst_no_done", done_q.size(), 0);
        #1 rst_n = 1'b1;
        run_job(0, 8, 16'h4000, 16'hA000, 16'h0300);

        // randomized jobs, including address wrap on source, gamma and destination
        for (int j = 0; j < 12; j++) begin
            int m, n, s, d, g;
            m = $urandom_range(0, 1);
            n = $urandom_range(1, 16);
            s = 16'h1000 + $urandom_range(0, 16'h0FFF);
            d = 16'h8000 + $urandom_range(0, 16'h0FFF);
            g = $urandom_range(0, 16'hFFFF);
            if (j == 0) begin s = 16'hFFFC; d = 16'h7FFE; g = 16'hFFFA; n = 8; end
            if (j == 1) begin s = 16'h2000; d = 16'hFFFD; n = 7; end
            load_rand(n, s, g);
            run_job(m, n, s, d, g);
        end

        b1 = rd_cnt;
        repeat (3) @(negedge clk);
        chk("idle_quiet", rd_cnt - b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
